// File: rtl/uart_rx.sv
// UART receiver: start bit, DATA_BITS data bits LSB first, one stop bit.
// The rx line is synchronised, sampled at bit centres using an oversampling
// tick, and each frame ends with a one-clock valid or frame_err strobe.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 valid,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Mid start bit is half a bit period in; later samples are a full period apart.
  localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE/2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic                 r_sync1, r_sync2;
  state_t               r_state;
  logic [SW-1:0]        r_s_cnt;
  logic [BW-1:0]        r_b_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid, r_ferr;

  logic                 w_rx_s;
  state_t               w_state_nxt;
  logic [SW-1:0]        w_s_cnt_nxt;
  logic [BW-1:0]        w_b_cnt_nxt;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic [DATA_BITS-1:0] w_data_nxt;
  logic                 w_valid_nxt, w_ferr_nxt;

  assign w_rx_s = r_sync2;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // Next-state, counter, shift and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_s_cnt_nxt = r_s_cnt;
    w_b_cnt_nxt = r_b_cnt;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_ferr_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Falling edge is acted on immediately, tick or not.
        if (!w_rx_s) begin
          w_state_nxt = START;
          w_s_cnt_nxt = '0;
        end
      end
      START: begin
        if (tick) begin
          if (r_s_cnt == S_MID) begin
            w_s_cnt_nxt = '0;
            if (!w_rx_s) begin
              w_state_nxt = DATA;
              w_b_cnt_nxt = '0;
            end else begin
              // Line went back high before mid-bit: treat as a glitch.
              w_state_nxt = IDLE;
            end
          end else begin
            w_s_cnt_nxt = r_s_cnt + SW'(1);
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (r_s_cnt == S_LAST) begin
            w_shift_nxt              = r_shift >> 1;
            w_shift_nxt[DATA_BITS-1] = w_rx_s;
            w_s_cnt_nxt              = '0;
            if (r_b_cnt == B_LAST) w_state_nxt = STOP;
            else                   w_b_cnt_nxt = r_b_cnt + BW'(1);
          end else begin
            w_s_cnt_nxt = r_s_cnt + SW'(1);
          end
        end
      end
      STOP: begin
        // Leaving at mid stop bit lets an immediately following start bit in.
        if (tick) begin
          if (r_s_cnt == S_LAST) begin
            w_s_cnt_nxt = '0;
            w_state_nxt = IDLE;
            if (w_rx_s) begin
              w_data_nxt  = r_shift;
              w_valid_nxt = 1'b1;
            end else begin
              w_ferr_nxt  = 1'b1;
            end
          end else begin
            w_s_cnt_nxt = r_s_cnt + SW'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_s_cnt <= '0;
      r_b_cnt <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s_cnt <= w_s_cnt_nxt;
      r_b_cnt <= w_b_cnt_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  assign data_out  = r_data;
  assign valid     = r_valid;
  assign frame_err = r_ferr;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: 16 ticks per bit, one tick every 4 clk
// (64 clk per bit). Expected strobes are queued as frames are sent; a monitor
// records observed strobes, and each test drains and compares both queues.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       valid, frame_err, busy;

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .rx(rx),
    .data_out(data_out), .valid(valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // tick: one clk wide, every 4th clk
  int unsigned tcnt = 0;
  initial forever begin
    @(negedge clk);
    tcnt++;
    tick = (tcnt % 4 == 0);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t exp_q[$];
  ev_t obs_q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  logic prev_strobe = 1'b0;

  // Record every strobe; strobes must be exclusive and one clk wide.
  always @(negedge clk) begin : mon
    ev_t e;
    if (valid === 1'b1 || frame_err === 1'b1) begin
      e.is_err = frame_err;
      e.data   = data_out;
      e.cyc    = cyc;
      obs_q.push_back(e);
      n_chk++;
      if ((valid & frame_err) !== 1'b0) begin
        n_fail++;
        $display("FAIL strobe_excl: valid=%b frame_err=%b, required not both", valid, frame_err);
      end
      n_chk++;
      if (prev_strobe !== 1'b0) begin
        n_fail++;
        $display("FAIL strobe_width: strobe high on consecutive clk at cyc %0d", cyc);
      end
    end
    prev_strobe = (valid === 1'b1) || (frame_err === 1'b1);
  end

  // Drive one frame starting at the current negedge; returns at a negedge.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_len,
                            output int t0);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      repeat ((i == 9) ? stop_len : 64) @(negedge clk);
    end
  endtask

  task automatic push_exp(input logic is_err, input logic [7:0] d);
    ev_t e;
    e.is_err = is_err;
    e.data   = d;
    e.cyc    = 0;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rx = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h need 00", data_out); end
    n_chk++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b need 0", valid); end
    n_chk++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_ferr: got %b need 0", frame_err); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b need 0", busy); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (320) @(negedge clk);
    n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL idle_strobes: got %0d need 0", obs_q.size()); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b need 0", busy); end
    obs_q.delete();
  endtask

  task automatic test_single();
    int t0, lat;
    ev_t e, o;
    push_exp(1'b0, 8'hA5);
    send_frame(8'hA5, 1'b1, 64, t0);
    rx = 1'b1;
    repeat (128) @(negedge clk);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL single_count: got %0d strobes need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++; if (o.is_err !== e.is_err) begin n_fail++; $display("FAIL single_kind: frame_err=%b need %b", o.is_err, e.is_err); end
      n_chk++; if (o.data !== e.data) begin n_fail++; $display("FAIL single_data: got %h need %h", o.data, e.data); end
      // 152 ticks from entering START, plus 3 clk sync/detect, tick phase 1..4
      lat = o.cyc - t0;
      n_chk++; if (lat < 608 || lat > 611) begin n_fail++; $display("FAIL single_latency: got %0d clk need 608..611", lat); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_glitch();
    rx = 1'b0;
    repeat (8) @(negedge clk);
    n_chk++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_hi: got %b need 1", busy); end
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_lo: got %b need 0", busy); end
    repeat (128) @(negedge clk);
    n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL glitch_strobes: got %0d need 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_frame_err();
    int t0;
    ev_t e, o;
    push_exp(1'b1, 8'hA5);  // data_out must keep the previous good byte
    send_frame(8'h3C, 1'b0, 48, t0);
    rx = 1'b1;
    repeat (128) @(negedge clk);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL ferr_count: got %0d strobes need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++; if (o.is_err !== e.is_err) begin n_fail++; $display("FAIL ferr_kind: frame_err=%b need %b", o.is_err, e.is_err); end
      n_chk++; if (o.data !== e.data) begin n_fail++; $display("FAIL ferr_data: got %h need %h", o.data, e.data); end
    end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ferr_busy: got %b need 0", busy); end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    int t0;
    ev_t e, o;
    logic [7:0] pat [3];
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      push_exp(1'b0, pat[i]);
      send_frame(pat[i], 1'b1, 64, t0);
    end
    rx = 1'b1;
    repeat (128) @(negedge clk);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL b2b_count: got %0d strobes need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++; if (o.is_err !== e.is_err) begin n_fail++; $display("FAIL b2b_kind: frame_err=%b need %b", o.is_err, e.is_err); end
      n_chk++; if (o.data !== e.data) begin n_fail++; $display("FAIL b2b_data: got %h need %h", o.data, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    int t0;
    ev_t e, o;
    logic [7:0] d;
    d = 8'h55;
    rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      repeat (64) @(negedge clk);
    end
    rx = d[3];
    repeat (30) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL rstmid_data: got %h need 00", data_out); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b need 0", busy); end
    n_chk++; if ((valid | frame_err) !== 1'b0) begin n_fail++; $display("FAIL rstmid_strobe: got %b%b need 00", valid, frame_err); end
    repeat (3) @(negedge clk);
    rx = 1'b1;
    rst_n = 1'b1;
    repeat (128) @(negedge clk);
    n_chk++; if (obs_q.size() != 0) begin n_fail++; $display("FAIL rstmid_aborted: got %0d strobes need 0", obs_q.size()); end
    obs_q.delete();
    push_exp(1'b0, 8'h81);
    send_frame(8'h81, 1'b1, 64, t0);
    rx = 1'b1;
    repeat (128) @(negedge clk);
    n_chk++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++; $display("FAIL rstmid_count: got %0d strobes need %0d", obs_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      n_chk++; if (o.is_err !== e.is_err) begin n_fail++; $display("FAIL rstmid_kind: frame_err=%b need %b", o.is_err, e.is_err); end
      n_chk++; if (o.data !== e.data) begin n_fail++; $display("FAIL rstmid_data2: got %h need %h", o.data, e.data); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_glitch();
    test_frame_err();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
